// File: rtl/spi_slave_bridge.sv
// SPI mode-0 target that turns 8-bit command + DATA_W-bit data frames into local register-bus
// read/write strobes; every SPI input is oversampled in the FCLK_CLK0 domain.
module spi_slave_bridge #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              FCLK_CLK0,
    input  logic              RST,
    input  logic              i_sclk,
    input  logic              i_mosi,
    input  logic              i_cs_n,
    output logic              o_miso,
    output logic              o_miso_oe,
    output logic              o_wr_en,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic              o_frame_done,
    output logic              o_frame_err
);

    localparam int CNT_MAX = (DATA_W > 8) ? DATA_W : 8;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT_CS} state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic                   sclk_last_q, mosi_last_q, cs_last_q;

    // NOTE: the cs_n chain resets low, so a frame already in flight when RST drops never
    // shows a falling edge and is ignored until cs_n goes high and falls again.
    always_ff @(posedge FCLK_CLK0 or posedge RST) begin
        if (RST) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_last_q <= 1'b0;
            mosi_last_q <= 1'b0;
            cs_last_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_cs_n};
            sclk_last_q <= sclk_sync_q[SYNC_STAGES-1];
            mosi_last_q <= mosi_sync_q[SYNC_STAGES-1];
            cs_last_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    assign sclk_rise = sclk_sync_q[SYNC_STAGES-1] & ~sclk_last_q;
    assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-1] & sclk_last_q;
    assign cs_rise   = cs_sync_q[SYNC_STAGES-1] & ~cs_last_q;
    assign cs_fall   = ~cs_sync_q[SYNC_STAGES-1] & cs_last_q;

    state_e             state_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [6:0]         cmd_sr_q;
    logic [DATA_W-2:0]  rx_sr_q;
    logic [DATA_W-1:0]  tx_sr_q;
    logic               write_q;
    logic               rd_cap_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               wr_en_q, rd_en_q, miso_q, miso_oe_q, done_q, err_q;

    logic [7:0]        cmd_d;
    logic [DATA_W-1:0] rx_d;
    logic [CNT_W-1:0]  bit_cnt_d;
    assign cmd_d     = {cmd_sr_q, mosi_last_q};
    assign rx_d      = {rx_sr_q, mosi_last_q};
    assign bit_cnt_d = (bit_cnt_q == CNT_W'(CNT_MAX)) ? bit_cnt_q : bit_cnt_q + 1'b1;

    always_ff @(posedge FCLK_CLK0 or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            cmd_sr_q  <= '0;
            rx_sr_q   <= '0;
            tx_sr_q   <= '0;
            write_q   <= 1'b0;
            rd_cap_q  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            // NOTE: strobes default low here so every path below yields a single-cycle pulse.
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            rd_cap_q <= rd_en_q;

            case (state_q)
                IDLE: begin
                    miso_q    <= 1'b0;
                    miso_oe_q <= 1'b0;
                    if (cs_fall) begin
                        state_q   <= CMD;
                        bit_cnt_q <= '0;
                        miso_oe_q <= 1'b1;
                    end
                end
                CMD: begin
                    miso_q <= 1'b0;
                    if (cs_rise) begin
                        state_q   <= IDLE;
                        err_q     <= 1'b1;
                        miso_oe_q <= 1'b0;
                    end else if (sclk_rise) begin
                        cmd_sr_q <= cmd_d[6:0];
                        if (bit_cnt_q == CNT_W'(7)) begin
                            addr_q    <= cmd_d[ADDR_W-1:0];
                            write_q   <= cmd_d[7];
                            rd_en_q   <= ~cmd_d[7];
                            bit_cnt_q <= '0;
                            state_q   <= DATA;
                        end else begin
                            bit_cnt_q <= bit_cnt_d;
                        end
                    end
                end
                DATA: begin
                    if (cs_rise) begin
                        state_q   <= IDLE;
                        err_q     <= 1'b1;
                        miso_q    <= 1'b0;
                        miso_oe_q <= 1'b0;
                    end else begin
                        if (sclk_fall && !write_q) begin
                            miso_q  <= tx_sr_q[DATA_W-1];
                            tx_sr_q <= tx_sr_q << 1;
                        end
                        if (sclk_rise) begin
                            bit_cnt_q <= bit_cnt_d;
                            if (write_q) rx_sr_q <= rx_d[DATA_W-2:0];
                            if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                                state_q <= WAIT_CS;
                                if (write_q) begin
                                    wdata_q <= rx_d;
                                    wr_en_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
                WAIT_CS: begin
                    miso_q <= 1'b0;
                    if (cs_rise) begin
                        state_q   <= IDLE;
                        done_q    <= 1'b1;
                        miso_oe_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Read data lands one cycle after the strobe; it wins over a coincident shift.
            if (rd_cap_q) tx_sr_q <= i_rdata;
        end
    end

    assign o_miso       = miso_q;
    assign o_miso_oe    = miso_oe_q;
    assign o_wr_en      = wr_en_q;
    assign o_rd_en      = rd_en_q;
    assign o_addr       = addr_q;
    assign o_wdata      = wdata_q;
    assign o_frame_done = done_q;
    assign o_frame_err  = err_q;

endmodule

// File: tb/tb_spi_slave_bridge.sv
// Directed bench for spi_slave_bridge: acts as an SPI master at SCLK = FCLK/16 and logs the
// local-bus strobes produced by the bridge.
module tb_spi_slave_bridge;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int HALF   = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sclk = 1'b0;
    logic              mosi = 1'b0;
    logic              cs_n = 1'b1;
    logic [DATA_W-1:0] rdata = '0;
    logic              miso, miso_oe, wr_en, rd_en, frame_done, frame_err;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    spi_slave_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .FCLK_CLK0   (clk),
        .RST         (rst),
        .i_sclk      (sclk),
        .i_mosi      (mosi),
        .i_cs_n      (cs_n),
        .o_miso      (miso),
        .o_miso_oe   (miso_oe),
        .o_wr_en     (wr_en),
        .o_rd_en     (rd_en),
        .o_addr      (addr),
        .o_wdata     (wdata),
        .i_rdata     (rdata),
        .o_frame_done(frame_done),
        .o_frame_err (frame_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int wr_cnt   = 0;
    int rd_cnt   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    logic [ADDR_W+DATA_W-1:0] wr_log[$];
    logic [ADDR_W-1:0]        rd_log[$];

    // Bus monitor samples on the falling FCLK edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_cnt++;
            wr_log.push_back({addr, wdata});
        end
        if (rd_en) begin
            rd_cnt++;
            rd_log.push_back(addr);
        end
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W+DATA_W-1:0] pop_wr();
        if (wr_log.size() > 0) return wr_log.pop_front();
        return '1;
    endfunction

    function automatic logic [ADDR_W-1:0] pop_rd();
        if (rd_log.size() > 0) return rd_log.pop_front();
        return '1;
    endfunction

    task automatic spi_bit(input logic b, output logic m, output logic oe);
        mosi = b;
        repeat (HALF) @(negedge clk);
        sclk = 1'b1;
        m    = miso;
        oe   = miso_oe;
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input logic [63:0] data, input int nbits,
                             input int gap, output logic [7:0] cmd_miso,
                             output logic [63:0] rx, output logic oe_all);
        logic m, oe;
        cs_n = 1'b0;
        rx = '0;
        oe_all = 1'b1;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            spi_bit(cmd[7-i], m, oe);
            cmd_miso[7-i] = m;
            oe_all &= oe;
        end
        for (int i = 0; i < nbits; i++) begin
            spi_bit(data[nbits-1-i], m, oe);
            rx = {rx[62:0], m};
            oe_all &= oe;
        end
        repeat (HALF) @(negedge clk);
        mosi = 1'b0;
        cs_n = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  cm;
        logic [63:0] rx;
        logic        oe_all, m, oe;
        logic [7:0]  rst_cmd;
        logic [31:0] rst_data;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outputs", {miso, miso_oe, wr_en, rd_en, frame_done, frame_err}, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", wdata, 0);
        rst = 1'b0;
        repeat (6) @(negedge clk);

        // Write 0xDEADBEEF to 0x05
        spi_frame(8'h85, 64'hDEAD_BEEF, 32, 12, cm, rx, oe_all);
        check("wr1_count", wr_cnt, 1);
        check("wr1_addr_data", pop_wr(), {7'h05, 32'hDEAD_BEEF});
        check("wr1_done", done_cnt, 1);
        check("wr1_oe_during_frame", oe_all, 1);
        check("wr1_oe_after", miso_oe, 0);

        // Read from 0x03
        rdata = 32'hA5A5_0F0F;
        spi_frame(8'h03, 64'h0, 32, 12, cm, rx, oe_all);
        check("rd_count", rd_cnt, 1);
        check("rd_addr", pop_rd(), 7'h03);
        check("rd_miso_data", rx[31:0], 32'hA5A5_0F0F);
        check("rd_miso_cmd_zero", cm, 0);
        check("rd_no_write", wr_cnt, 1);
        check("rd_done", done_cnt, 2);

        // Write aborted after 20 data bits, then a normal write
        spi_frame(8'h85, 64'h0_ABCD, 20, 12, cm, rx, oe_all);
        check("abort_no_write", wr_cnt, 1);
        check("abort_err", err_cnt, 1);
        check("abort_no_done", done_cnt, 2);
        spi_frame(8'h86, 64'h0102_0304, 32, 12, cm, rx, oe_all);
        check("post_abort_count", wr_cnt, 2);
        check("post_abort_addr_data", pop_wr(), {7'h06, 32'h0102_0304});

        // 48 data clocks: trailing 16 bits ignored
        spi_frame(8'h8A, {32'hCAFE_F00D, 16'hFFFF}, 48, 12, cm, rx, oe_all);
        check("long_count", wr_cnt, 3);
        check("long_addr_data", pop_wr(), {7'h0A, 32'hCAFE_F00D});
        check("long_done", done_cnt, 4);
        check("long_no_err", err_cnt, 1);

        // RST after 4th command bit of a write to 0x7F
        rst_cmd  = 8'hFF;
        rst_data = 32'h1234_5678;
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int i = 0; i < 4; i++) spi_bit(rst_cmd[7-i], m, oe);
        check("midframe_oe", miso_oe, 1);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {miso, miso_oe, wr_en, rd_en, frame_done, frame_err}, 0);
        check("midrst_addr", addr, 0);
        check("midrst_wdata", wdata, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 4; i < 8; i++) spi_bit(rst_cmd[7-i], m, oe);
        for (int i = 0; i < 32; i++) spi_bit(rst_data[31-i], m, oe);
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (12) @(negedge clk);
        check("postrst_tail_ignored", {wr_cnt[7:0], done_cnt[7:0], err_cnt[7:0]}, {8'd3, 8'd4, 8'd1});
        spi_frame(8'hFF, 64'h1234_5678, 32, 12, cm, rx, oe_all);
        check("postrst_count", wr_cnt, 4);
        check("postrst_addr_data", pop_wr(), {7'h7F, 32'h1234_5678});

        // Three back-to-back writes separated by 2-cycle cs_n gaps
        spi_frame(8'h81, 64'h1111_1111, 32, 2, cm, rx, oe_all);
        spi_frame(8'h82, 64'h2222_2222, 32, 2, cm, rx, oe_all);
        spi_frame(8'h83, 64'h3333_3333, 32, 12, cm, rx, oe_all);
        check("b2b_count", wr_cnt, 7);
        check("b2b_first", pop_wr(), {7'h01, 32'h1111_1111});
        check("b2b_second", pop_wr(), {7'h02, 32'h2222_2222});
        check("b2b_third", pop_wr(), {7'h03, 32'h3333_3333});
        check("b2b_done", done_cnt, 8);
        check("b2b_no_err", err_cnt, 1);
        check("total_reads", rd_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
